src_buf_pp: RTL

Parametrised, multi-bank ping-pong source buffer feeding the tiny-dnn MAC core. Replaces the fixed two-bank, four-lane, 16-bit source buffer. The host/DMA side writes LANES words per beat into one bank while the core reads single words from another bank. Per-bank ownership state is explicit, so the fill side and the compute side hand banks back and forth without overlap.

---
 rtl/src_buf_pkg.sv | 15 +
 rtl/src_buf_pp_lane_ram.sv | 32 +++
 rtl/src_buf_pp.sv | 132 +++++++++++++
 3 files changed

// File: rtl/src_buf_pkg.sv
// rtl/src_buf_pkg.sv - shared bank state encoding and default parameters for the ping-pong source buffer
package src_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } bank_state_e;

    localparam int DEF_DW    = 16;
    localparam int DEF_LANES = 4;
    localparam int DEF_DEPTH = 1024;
    localparam int DEF_NBANK = 2;

endpackage

// File: rtl/src_buf_pp_lane_ram.sv
// rtl/src_buf_pp_lane_ram.sv - one lane of one bank: single write port, registered read port, no reset
module lane_ram
    import src_buf_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
        if (re) begin
            rd_q <= mem_q[ra];
        end
    end

    assign rd = rd_q;

endmodule

// File: rtl/src_buf_pp.sv
// rtl/src_buf_pp.sv - multi-bank ping-pong source buffer: LANES-wide fill side, single-word compute read side
module src_buf_pp
    import src_buf_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int LANES = DEF_LANES,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int NBANK = DEF_NBANK,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(LANES),
    localparam int BW    = $clog2(NBANK)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  src_v,
    input  logic [BW+AW-1:0]      src_a,
    input  logic [LANES*DW-1:0]   src_d,
    input  logic                  src_last,
    output logic [NBANK-1:0]      bank_free,
    output logic [NBANK-1:0]      bank_rdy,
    input  logic                  exec,
    input  logic [BW+AW+LW-1:0]   ia,
    output logic [DW-1:0]         d,
    output logic                  d_v,
    input  logic                  rd_rel,
    input  logic [BW-1:0]         rd_bank,
    output logic                  err
);

    logic [BW-1:0] wr_bank;
    logic [AW-1:0] wr_word;
    logic [BW-1:0] ex_bank;
    logic [AW-1:0] ex_word;
    logic [LW-1:0] ex_lane;

    assign wr_bank = src_a[AW +: BW];
    assign wr_word = src_a[AW-1:0];
    assign ex_bank = ia[AW+LW +: BW];
    assign ex_word = ia[LW +: AW];
    assign ex_lane = ia[LW-1:0];

    bank_state_e   state_q [NBANK];
    bank_state_e   state_d [NBANK];
    logic          err_q, err_d;
    logic          rv_q, rv_d;
    logic [BW-1:0] sel_bank_q, sel_bank_d;
    logic [LW-1:0] sel_lane_q, sel_lane_d;
    logic [DW-1:0] d_q, d_d;
    logic          dv_q, dv_d;
    logic          wr_ok, ex_ok, rel_ok;

    logic [DW-1:0] ram_rd [NBANK*LANES];

    always_comb begin
        wr_ok  = src_v  && (state_q[wr_bank] != FULL);
        ex_ok  = exec   && (state_q[ex_bank] == FULL);
        rel_ok = rd_rel && (state_q[rd_bank] == FULL);

        // A release wins over a write on the same bank: that write already failed since the bank was FULL.
        for (int b = 0; b < NBANK; b++) begin
            state_d[b] = state_q[b];
            if (rel_ok && rd_bank == BW'(b)) begin
                state_d[b] = EMPTY;
            end else if (wr_ok && wr_bank == BW'(b)) begin
                state_d[b] = src_last ? FULL : FILL;
            end
        end

        err_d = err_q | (src_v && !wr_ok) | (exec && !ex_ok) | (rd_rel && !rel_ok);

        rv_d       = ex_ok;
        sel_bank_d = ex_ok ? ex_bank : sel_bank_q;
        sel_lane_d = ex_ok ? ex_lane : sel_lane_q;

        // Array index {bank, lane} equals bank*LANES + lane because LANES is a power of two.
        d_d  = rv_q ? ram_rd[{sel_bank_q, sel_lane_q}] : d_q;
        dv_d = rv_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANK; b++) begin
                state_q[b] <= EMPTY;
            end
            err_q      <= 1'b0;
            rv_q       <= 1'b0;
            sel_bank_q <= '0;
            sel_lane_q <= '0;
            d_q        <= '0;
            dv_q       <= 1'b0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                state_q[b] <= state_d[b];
            end
            err_q      <= err_d;
            rv_q       <= rv_d;
            sel_bank_q <= sel_bank_d;
            sel_lane_q <= sel_lane_d;
            d_q        <= d_d;
            dv_q       <= dv_d;
        end
    end

    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            bank_free[b] = (state_q[b] != FULL);
            bank_rdy[b]  = (state_q[b] == FULL);
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            lane_ram #(
                .DW    (DW),
                .DEPTH (DEPTH)
            ) u_ram (
                .clk (clk),
                .we  (wr_ok && wr_bank == BW'(b)),
                .wa  (wr_word),
                .wd  (src_d[l*DW +: DW]),
                .re  (ex_ok && ex_bank == BW'(b) && ex_lane == LW'(l)),
                .ra  (ex_word),
                .rd  (ram_rd[b*LANES + l])
            );
        end
    end

    assign d   = d_q;
    assign d_v = dv_q;
    assign err = err_q;

endmodule
